// File: rtl/alu_seq_unit.sv
// Sequenced ALU with an NREGS x WIDTH register file, valid/ready command and result ports,
// single-cycle ops plus a WIDTH-iteration shift-add multiply.
module alu_seq_unit #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [AW-1:0]    cmd_src_a,
   input  logic [AW-1:0]    cmd_src_b,
   input  logic [AW-1:0]    cmd_dst,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [3:0]       res_flags,
   output logic             busy
);

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
                          OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7,
                          OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_MUL = 4'd10, OP_ACC = 4'd11;
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0]   regs [NREGS];
   logic [WIDTH-1:0]   a_q, b_q, mplier_q;
   logic [3:0]         op_q;
   logic [AW-1:0]      dst_q;
   logic [2*WIDTH-1:0] prod_q, mcand_q;
   logic [CW-1:0]      cnt_q;

   logic               accept, finish, res_take;
   logic [WIDTH:0]     sum_w, diff_w;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   assign accept   = cmd_valid & cmd_ready;
   assign finish   = (state == S_DONE) & ~res_valid;
   assign res_take = (state == S_DONE) & res_valid & res_ready;

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept) state_nx = S_EXEC;
         S_EXEC: state_nx = (op_q == OP_MUL) ? S_MUL : S_DONE;
         S_MUL:  if (cnt_q == CW'(WIDTH - 1)) state_nx = S_DONE;
         S_DONE: if (res_take) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = rst & (state == S_IDLE);
      busy      = (state != S_IDLE);
   end

   // ACC reuses the ADD path: b_q holds reg[dst] captured at accept.
   always_comb begin
      sum_w   = {1'b0, a_q} + {1'b0, b_q};
      diff_w  = {1'b0, a_q} - {1'b0, b_q};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         OP_ADD, OP_ACC: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_w[WIDTH-1:0];
            alu_c   = ~diff_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_NOT: alu_res = ~a_q;
         OP_SHL: begin alu_res = {a_q[WIDTH-2:0], 1'b0};        alu_c = a_q[WIDTH-1]; end
         OP_SHR: begin alu_res = {1'b0, a_q[WIDTH-1:1]};        alu_c = a_q[0];       end
         OP_ROL: begin alu_res = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; alu_c = a_q[WIDTH-1]; end
         OP_ROR: begin alu_res = {a_q[0], a_q[WIDTH-1:1]};       alu_c = a_q[0];       end
         OP_MUL: begin alu_res = prod_q[WIDTH-1:0]; alu_c = |prod_q[2*WIDTH-1:WIDTH]; end
         default: ;
      endcase
   end

   // Later assignments to regs[] win, so ALU writeback overrides a same-address wr_en.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         dst_q     <= '0;
         prod_q    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_flags <= '0;
      end else begin
         if (accept) begin
            a_q      <= regs[cmd_src_a];
            b_q      <= (cmd_op == OP_ACC) ? regs[cmd_dst] : regs[cmd_src_b];
            op_q     <= cmd_op;
            dst_q    <= cmd_dst;
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, regs[cmd_src_a]};
            mplier_q <= regs[cmd_src_b];
            cnt_q    <= '0;
         end
         if (state == S_MUL) begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
         end
         if (wr_en) regs[wr_addr] <= wr_data;
         if (finish) begin
            res_valid <= 1'b1;
            res_data  <= alu_res;
            res_flags <= {alu_c, alu_v, alu_res[WIDTH-1], (alu_res == '0)};
            if (op_q <= OP_ACC) regs[dst_q] <= alu_res;
         end else if (res_take) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule
